// File: rtl/intc_pkg.sv
// Shared context type, vector-address helper and reset constants for intc_nested.
package intc_pkg;

   // Context fields are sized for the widest supported build (64 sources, 32-bit PC).
   localparam int INTC_ADDR_MAX = 32;
   localparam int INTC_ID_MAX   = 6;

   typedef struct packed {
      logic                     valid;
      logic [INTC_ADDR_MAX-1:0] ret_addr;
      logic [INTC_ID_MAX-1:0]   prev_id;
   } intc_ctx_t;

   localparam intc_ctx_t INTC_CTX_RST    = '0;
   localparam logic      INTC_ENABLE_RST = 1'b0;
   localparam logic      INTC_SPUR_RST   = 1'b0;

   function automatic logic [INTC_ADDR_MAX-1:0] intc_vec_addr(
      input logic [INTC_ADDR_MAX-1:0] base,
      input logic [INTC_ADDR_MAX-1:0] stride,
      input logic [INTC_ID_MAX-1:0]   id
   );
      return base + INTC_ADDR_MAX'(id) * stride;
   endfunction

endpackage

// File: rtl/intc_ctx_stack.sv
// LIFO of interrupted contexts; top is the most recent push, valid only while level is non-zero.
module intc_ctx_stack
   import intc_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int LVL_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  intc_ctx_t        din,
   output intc_ctx_t        top,
   output logic [LVL_W-1:0] level
);

   logic [LVL_W-1:0] level_reg;
   intc_ctx_t        ents [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         level_reg <= '0;
      end else if (push) begin
         level_reg <= level_reg + LVL_W'(1);
      end else if (pop) begin
         level_reg <= level_reg - LVL_W'(1);
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_ent
         intc_ctx_t ent;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               ent <= INTC_CTX_RST;
            end else if (push && level_reg == LVL_W'(gi)) begin
               ent <= din;
            end else if (pop && level_reg == LVL_W'(gi + 1)) begin
               ent.valid <= 1'b0;
            end
         end
         assign ents[gi] = ent;
      end
   endgenerate

   always_comb begin
      top = INTC_CTX_RST;
      for (int i = 0; i < DEPTH; i++) begin
         if (level_reg == LVL_W'(i + 1)) top = ents[i];
      end
   end

   assign level = level_reg;

endmodule

// File: rtl/intc_nested.sv
// Nested vectored interrupt controller: IER/IFR bank, fixed-priority pick, context stack.
// Preemption is built only with INTC_NESTING_EN defined; otherwise a single handler level.
module intc_nested
   import intc_pkg::*;
#(
   parameter int                NUM_INT    = 16,
   parameter int                ADDR_W     = 16,
   parameter int                NEST_DEPTH = 4,
   parameter logic [ADDR_W-1:0] VEC_BASE   = 16'h0100,
   parameter int                VEC_STRIDE = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [$clog2(NUM_INT):0]        reg_addr,
   input  logic                            ier_set_flag,
   input  logic                            ier_unset_flag,
   input  logic                            ifr_set_flag,
   input  logic                            ifr_unset_flag,
   input  logic [NUM_INT-1:0]              irq_in,
   input  logic [ADDR_W-1:0]               rtrn_addr_in,
   input  logic                            end_routine,
   output logic                            enable,
   output logic [ADDR_W-1:0]               addr_out,
   output logic [$clog2(NUM_INT)-1:0]      active_id,
   output logic [$clog2(NEST_DEPTH+1)-1:0] nest_level,
   output logic                            spurious_end
);

   localparam int ID_W  = $clog2(NUM_INT);
   localparam int RA_W  = $clog2(NUM_INT) + 1;
   localparam int LVL_W = $clog2(NEST_DEPTH + 1);
`ifdef INTC_NESTING_EN
   localparam int EFF_DEPTH = NEST_DEPTH;
`else
   localparam int EFF_DEPTH = 1;
`endif

   logic [NUM_INT:0]   ier_reg, ier_next;
   logic [NUM_INT-1:0] ifr_reg, ifr_next;
   logic [NUM_INT-1:0] cand;
   logic [ID_W-1:0]    win_id;
   logic [ID_W-1:0]    active_id_reg;
   logic               enable_reg;
   logic               spurious_reg;
   logic [ADDR_W-1:0]  addr_reg;
   logic [LVL_W-1:0]   level;
   logic               prio_ok, take, pop, spur;
   intc_ctx_t          ctx_push, ctx_top;
   logic [INTC_ADDR_MAX-1:0] vec_full;
   logic               ctx_unused;

   assign cand = ier_reg[NUM_INT-1:0] & ifr_reg;

   // Lowest set index wins.
   always_comb begin
      win_id = '0;
      for (int i = NUM_INT - 1; i >= 0; i--) begin
         if (cand[i]) win_id = ID_W'(i);
      end
   end

`ifdef INTC_NESTING_EN
   assign prio_ok = (level == '0) || (win_id < active_id_reg);
`else
   assign prio_ok = (level == '0);
`endif

   assign take = ier_reg[NUM_INT] && (|cand) && !end_routine && !enable_reg
                 && (level < LVL_W'(EFF_DEPTH)) && prio_ok;
   assign pop  = end_routine && (level != '0);
   assign spur = end_routine && (level == '0);

   genvar gi;
   generate
      for (gi = 0; gi <= NUM_INT; gi++) begin : g_ier
         logic hit;
         assign hit          = (reg_addr == RA_W'(gi));
         assign ier_next[gi] = (hit && ier_set_flag)   ? 1'b1 :
                               (hit && ier_unset_flag) ? 1'b0 : ier_reg[gi];
      end
      // The take-clear outranks every set source for the same bit.
      for (gi = 0; gi < NUM_INT; gi++) begin : g_ifr
         logic hit, set;
         assign hit          = (reg_addr == RA_W'(gi));
         assign set          = (hit && ifr_set_flag) || irq_in[gi];
         assign ifr_next[gi] = (take && win_id == ID_W'(gi)) ? 1'b0 :
                               set                           ? 1'b1 :
                               (hit && ifr_unset_flag)       ? 1'b0 : ifr_reg[gi];
      end
   endgenerate

   assign vec_full = intc_vec_addr(INTC_ADDR_MAX'(VEC_BASE), INTC_ADDR_MAX'(VEC_STRIDE),
                                   INTC_ID_MAX'(win_id));

   assign ctx_push.valid    = 1'b1;
   assign ctx_push.ret_addr = INTC_ADDR_MAX'(rtrn_addr_in);
   assign ctx_push.prev_id  = INTC_ID_MAX'(active_id_reg);

   intc_ctx_stack #(
      .DEPTH (EFF_DEPTH),
      .LVL_W (LVL_W)
   ) u_stack (
      .clk   (clk),
      .rst   (rst),
      .push  (take),
      .pop   (pop),
      .din   (ctx_push),
      .top   (ctx_top),
      .level (level)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ier_reg       <= '0;
         ifr_reg       <= '0;
         active_id_reg <= '0;
         addr_reg      <= '0;
         enable_reg    <= INTC_ENABLE_RST;
         spurious_reg  <= INTC_SPUR_RST;
      end else begin
         ier_reg      <= ier_next;
         ifr_reg      <= ifr_next;
         enable_reg   <= take || pop;
         spurious_reg <= spur;
         if (take) begin
            addr_reg      <= vec_full[ADDR_W-1:0];
            active_id_reg <= win_id;
         end else if (pop) begin
            addr_reg      <= ctx_top.ret_addr[ADDR_W-1:0];
            active_id_reg <= ctx_top.prev_id[ID_W-1:0];
         end
      end
   end

   // Upper context/vector bits beyond the configured widths are intentionally dropped.
   assign ctx_unused = ^{ctx_top, vec_full};

   assign enable       = enable_reg;
   assign addr_out     = addr_reg;
   assign active_id    = active_id_reg;
   assign nest_level   = level;
   assign spurious_end = spurious_reg;

endmodule

// File: tb/tb_intc_nested.sv
// Directed, table-driven bench for intc_nested (NEST_DEPTH=2); expectations follow INTC_NESTING_EN.
module tb_intc_nested;

`ifdef INTC_NESTING_EN
   localparam bit NEST = 1'b1;
`else
   localparam bit NEST = 1'b0;
`endif

   localparam logic [3:0] OP_NONE = 4'd0, IER_S = 4'd1, IER_U = 4'd2, IFR_S = 4'd4, IFR_U = 4'd8;

   typedef struct packed {
      logic        en;
      logic [15:0] addr;
      logic [3:0]  id;
      logic [1:0]  lvl;
      logic        sp;
   } exp_t;

   typedef struct {
      string       name;
      logic [4:0]  ra;
      logic [3:0]  op;
      logic [15:0] irq;
      logic [15:0] rtrn;
      logic        endr;
      exp_t        x;
   } vec_t;

   vec_t vecs[$];
   int   checks = 0;
   int   errors = 0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [4:0]  reg_addr = '0;
   logic        ier_set_flag = 1'b0, ier_unset_flag = 1'b0;
   logic        ifr_set_flag = 1'b0, ifr_unset_flag = 1'b0;
   logic [15:0] irq_in = '0;
   logic [15:0] rtrn_addr_in = '0;
   logic        end_routine = 1'b0;
   logic        enable;
   logic [15:0] addr_out;
   logic [3:0]  active_id;
   logic [1:0]  nest_level;
   logic        spurious_end;

   always #5 clk = ~clk;

   intc_nested #(
      .NUM_INT    (16),
      .ADDR_W     (16),
      .NEST_DEPTH (2),
      .VEC_BASE   (16'h0100),
      .VEC_STRIDE (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .reg_addr       (reg_addr),
      .ier_set_flag   (ier_set_flag),
      .ier_unset_flag (ier_unset_flag),
      .ifr_set_flag   (ifr_set_flag),
      .ifr_unset_flag (ifr_unset_flag),
      .irq_in         (irq_in),
      .rtrn_addr_in   (rtrn_addr_in),
      .end_routine    (end_routine),
      .enable         (enable),
      .addr_out       (addr_out),
      .active_id      (active_id),
      .nest_level     (nest_level),
      .spurious_end   (spurious_end)
   );

   function automatic exp_t e(logic en, logic [15:0] addr, logic [3:0] id, logic [1:0] lvl, logic sp);
      exp_t r;
      r.en = en; r.addr = addr; r.id = id; r.lvl = lvl; r.sp = sp;
      return r;
   endfunction

   task automatic add(string name, logic [4:0] ra, logic [3:0] op, logic [15:0] irq,
                      logic [15:0] rtrn, logic endr, exp_t xn, exp_t xf);
      vec_t v;
      v.name = name; v.ra = ra; v.op = op; v.irq = irq; v.rtrn = rtrn; v.endr = endr;
      v.x = NEST ? xn : xf;
      vecs.push_back(v);
   endtask

   task automatic add1(string name, logic [4:0] ra, logic [3:0] op, logic [15:0] irq,
                       logic [15:0] rtrn, logic endr, exp_t x);
      add(name, ra, op, irq, rtrn, endr, x, x);
   endtask

   task automatic chk(string name, logic [31:0] act, logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic check_outs(string name, exp_t x);
      chk({name, ".enable"},     32'(enable),       32'(x.en));
      chk({name, ".addr_out"},   32'(addr_out),     32'(x.addr));
      chk({name, ".active_id"},  32'(active_id),    32'(x.id));
      chk({name, ".nest_level"}, 32'(nest_level),   32'(x.lvl));
      chk({name, ".spurious"},   32'(spurious_end), 32'(x.sp));
   endtask

   task automatic drive(vec_t v);
      reg_addr       = v.ra;
      ier_set_flag   = v.op[0];
      ier_unset_flag = v.op[1];
      ifr_set_flag   = v.op[2];
      ifr_unset_flag = v.op[3];
      irq_in         = v.irq;
      rtrn_addr_in   = v.rtrn;
      end_routine    = v.endr;
   endtask

   initial begin
      // Basic take, lower-priority wait, pop, spurious end, global enable, set-over-unset.
      add1("gie_on",   5'd16, IER_S, 16'h0000, 16'h0000, 1'b0, e(0, 16'h0000, 0, 0, 0));
      add1("ier3",     5'd3,  IER_S, 16'h0000, 16'h0000, 1'b0, e(0, 16'h0000, 0, 0, 0));
      add1("irq3",     5'd0,  OP_NONE, 16'h0008, 16'h0040, 1'b0, e(0, 16'h0000, 0, 0, 0));
      add1("take3",    5'd0,  OP_NONE, 16'h0008, 16'h0040, 1'b0, e(1, 16'h010C, 3, 1, 0));
      add1("hold3",    5'd0,  OP_NONE, 16'h0000, 16'h0040, 1'b0, e(0, 16'h010C, 3, 1, 0));
      add1("ier1",     5'd1,  IER_S, 16'h0000, 16'h0000, 1'b0, e(0, 16'h010C, 3, 1, 0));
      add1("ier5",     5'd5,  IER_S, 16'h0000, 16'h0000, 1'b0, e(0, 16'h010C, 3, 1, 0));
      add1("irq5",     5'd0,  OP_NONE, 16'h0020, 16'h0000, 1'b0, e(0, 16'h010C, 3, 1, 0));
      add1("lowpri",   5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b0, e(0, 16'h010C, 3, 1, 0));
      add1("ier7",     5'd7,  IER_S, 16'h0000, 16'h0000, 1'b0, e(0, 16'h010C, 3, 1, 0));
      add1("ier4",     5'd4,  IER_S, 16'h0000, 16'h0000, 1'b0, e(0, 16'h010C, 3, 1, 0));
      add1("ier0",     5'd0,  IER_S, 16'h0000, 16'h0000, 1'b0, e(0, 16'h010C, 3, 1, 0));
      add1("ret3",     5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b1, e(1, 16'h0040, 0, 0, 0));
      add1("blackout", 5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b0, e(0, 16'h0040, 0, 0, 0));
      add1("take5",    5'd0,  OP_NONE, 16'h0000, 16'h0200, 1'b0, e(1, 16'h0114, 5, 1, 0));
      add1("hold5",    5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b0, e(0, 16'h0114, 5, 1, 0));
      add1("ret5",     5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b1, e(1, 16'h0200, 0, 0, 0));
      add1("idle0",    5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b0, e(0, 16'h0200, 0, 0, 0));
      add1("spur",     5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b1, e(0, 16'h0200, 0, 0, 1));
      add1("spur_off", 5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b0, e(0, 16'h0200, 0, 0, 0));
      add1("gie_off",  5'd16, IER_U, 16'h0000, 16'h0000, 1'b0, e(0, 16'h0200, 0, 0, 0));
      add1("ifr3_sw",  5'd3,  IFR_S, 16'h0000, 16'h0000, 1'b0, e(0, 16'h0200, 0, 0, 0));
      add1("masked",   5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b0, e(0, 16'h0200, 0, 0, 0));
      add1("gie_on2",  5'd16, IER_S, 16'h0000, 16'h0000, 1'b0, e(0, 16'h0200, 0, 0, 0));
      add1("take3b",   5'd0,  OP_NONE, 16'h0000, 16'h0300, 1'b0, e(1, 16'h010C, 3, 1, 0));
      add1("hold3b",   5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b0, e(0, 16'h010C, 3, 1, 0));
      add1("ret3b",    5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b1, e(1, 16'h0300, 0, 0, 0));
      add1("idle1",    5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b0, e(0, 16'h0300, 0, 0, 0));
      add1("set_wins", 5'd4,  IFR_U, 16'h0010, 16'h0000, 1'b0, e(0, 16'h0300, 0, 0, 0));
      add1("take4",    5'd0,  OP_NONE, 16'h0000, 16'h0400, 1'b0, e(1, 16'h0110, 4, 1, 0));
      add1("hold4",    5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b0, e(0, 16'h0110, 4, 1, 0));
      add1("ret4",     5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b1, e(1, 16'h0400, 0, 0, 0));
      add1("idle2",    5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b0, e(0, 16'h0400, 0, 0, 0));
      // Preemption of ID 3 by ID 1 (flat build: ID 1 waits for the return).
      add1("ifr3",     5'd3,  IFR_S, 16'h0000, 16'h0040, 1'b0, e(0, 16'h0400, 0, 0, 0));
      add1("take3c",   5'd0,  OP_NONE, 16'h0000, 16'h0040, 1'b0, e(1, 16'h010C, 3, 1, 0));
      add1("ifr1",     5'd1,  IFR_S, 16'h0000, 16'h0110, 1'b0, e(0, 16'h010C, 3, 1, 0));
      add("pre1",      5'd0,  OP_NONE, 16'h0000, 16'h0110, 1'b0, e(1, 16'h0104, 1, 2, 0), e(0, 16'h010C, 3, 1, 0));
      add("hold1",     5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b0, e(0, 16'h0104, 1, 2, 0), e(0, 16'h010C, 3, 1, 0));
      add("pop1",      5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b1, e(1, 16'h0110, 3, 1, 0), e(1, 16'h0040, 0, 0, 0));
      add("post1",     5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b0, e(0, 16'h0110, 3, 1, 0), e(0, 16'h0040, 0, 0, 0));
      add("late1",     5'd0,  OP_NONE, 16'h0000, 16'h0500, 1'b0, e(0, 16'h0110, 3, 1, 0), e(1, 16'h0104, 1, 1, 0));
      add("pop2",      5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b1, e(1, 16'h0040, 0, 0, 0), e(1, 16'h0500, 0, 0, 0));
      add("post2",     5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b0, e(0, 16'h0040, 0, 0, 0), e(0, 16'h0500, 0, 0, 0));
      // Full stack: 7 then 4 nested, ID 0 must wait for one return.
      add("ifr7",      5'd7,  IFR_S, 16'h0000, 16'h0600, 1'b0, e(0, 16'h0040, 0, 0, 0), e(0, 16'h0500, 0, 0, 0));
      add1("take7",    5'd0,  OP_NONE, 16'h0000, 16'h0600, 1'b0, e(1, 16'h011C, 7, 1, 0));
      add1("ifr4",     5'd4,  IFR_S, 16'h0000, 16'h0700, 1'b0, e(0, 16'h011C, 7, 1, 0));
      add("pre4",      5'd0,  OP_NONE, 16'h0000, 16'h0700, 1'b0, e(1, 16'h0110, 4, 2, 0), e(0, 16'h011C, 7, 1, 0));
      add("ifr0",      5'd0,  IFR_S, 16'h0000, 16'h0000, 1'b0, e(0, 16'h0110, 4, 2, 0), e(0, 16'h011C, 7, 1, 0));
      add("full_a",    5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b0, e(0, 16'h0110, 4, 2, 0), e(0, 16'h011C, 7, 1, 0));
      add("full_b",    5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b0, e(0, 16'h0110, 4, 2, 0), e(0, 16'h011C, 7, 1, 0));
      add("pop4",      5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b1, e(1, 16'h0700, 7, 1, 0), e(1, 16'h0600, 0, 0, 0));
      add("post4",     5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b0, e(0, 16'h0700, 7, 1, 0), e(0, 16'h0600, 0, 0, 0));
      add("take0",     5'd0,  OP_NONE, 16'h0000, 16'h0800, 1'b0, e(1, 16'h0100, 0, 2, 0), e(1, 16'h0100, 0, 1, 0));
      add("hold0",     5'd0,  OP_NONE, 16'h0000, 16'h0000, 1'b0, e(0, 16'h0100, 0, 2, 0), e(0, 16'h0100, 0, 1, 0));

      repeat (2) @(negedge clk);
      check_outs("reset", e(0, 16'h0000, 0, 0, 0));
      rst = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         @(posedge clk);
         @(negedge clk);
         check_outs(vecs[i].name, vecs[i].x);
         $display("vec %0d %s en=%b addr=%h id=%0d lvl=%0d sp=%b", i, vecs[i].name,
                  enable, addr_out, active_id, nest_level, spurious_end);
      end

      // Asynchronous reset while handlers are active, then an end with nothing to return to.
      #2 rst = 1'b1;
      #1 check_outs("async_rst", e(0, 16'h0000, 0, 0, 0));
      $display("async_rst en=%b addr=%h lvl=%0d", enable, addr_out, nest_level);
      @(negedge clk);
      rst = 1'b0;
      end_routine = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_outs("post_rst_end", e(0, 16'h0000, 0, 0, 1));
      $display("post_rst_end en=%b sp=%b lvl=%0d", enable, spurious_end, nest_level);
      end_routine = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_outs("post_rst_idle", e(0, 16'h0000, 0, 0, 0));
         $display("post_rst_idle %0d en=%b sp=%b", i, enable, spurious_end);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
